// File: rtl/pipe_hazard_ctrl.sv
// Hazard/interrupt sequencer beside the ID stage: load-use stalls, branch flushes,
// and interrupt entry (drain, vector, mask) with exit on returni.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_rs1,
  input  logic [3:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_mem_rd,
  input  logic [3:0] ex_reg_dst,
  input  logic       id_branch_take,
  input  logic       id_returni,
  input  logic       irq,
  output logic       pc_hold,
  output logic       if_id_hold,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       pc_vec_sel,
  output logic       int_ack,
  output logic       in_isr
);

  localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    VECTOR = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             irq_pend_q, irq_pend_d;
  logic             in_isr_q, in_isr_d;
  logic             rst_dly_q;

  logic hazard;
  logic pc_hold_raw, if_id_hold_raw, if_id_flush_raw, id_ex_bubble_raw;
  logic pc_vec_sel_raw, int_ack_raw;
  logic out_gate;

  // rst_dly_q keeps every output quiet for one extra cycle after reset drops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      irq_pend_q  <= 1'b0;
      in_isr_q    <= 1'b0;
      rst_dly_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      irq_pend_q  <= irq_pend_d;
      in_isr_q    <= in_isr_d;
      rst_dly_q   <= 1'b0;
    end
  end

  always_comb begin
    hazard = id_valid && ex_mem_rd &&
             ((id_use_rs1 && (id_rs1 == ex_reg_dst)) ||
              (id_use_rs2 && (id_rs2 == ex_reg_dst)));

    state_d          = state_q;
    drain_cnt_d      = drain_cnt_q;
    irq_pend_d       = irq_pend_q;
    in_isr_d         = in_isr_q;
    pc_hold_raw      = 1'b0;
    if_id_hold_raw   = 1'b0;
    if_id_flush_raw  = 1'b0;
    id_ex_bubble_raw = 1'b0;
    pc_vec_sel_raw   = 1'b0;
    int_ack_raw      = 1'b0;

    // Requests are only latched from RUN; the ISR masks them entirely
    if ((state_q == RUN) && irq && !in_isr_q) begin
      irq_pend_d = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (hazard) begin
          pc_hold_raw      = 1'b1;
          if_id_hold_raw   = 1'b1;
          id_ex_bubble_raw = 1'b1;
        end else if (id_valid && id_branch_take) begin
          if_id_flush_raw = 1'b1;
        end else if (id_valid && id_returni && in_isr_q) begin
          in_isr_d = 1'b0;
        end else if (irq_pend_q) begin
          state_d     = DRAIN;
          drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        pc_hold_raw     = 1'b1;
        if_id_flush_raw = 1'b1;
        if (drain_cnt_q == '0) begin
          state_d = VECTOR;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      VECTOR: begin
        pc_vec_sel_raw  = 1'b1;
        int_ack_raw     = 1'b1;
        if_id_flush_raw = 1'b1;
        irq_pend_d      = 1'b0;
        in_isr_d        = 1'b1;
        state_d         = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    out_gate     = rst || rst_dly_q;
    pc_hold      = pc_hold_raw      && !out_gate;
    if_id_hold   = if_id_hold_raw   && !out_gate;
    if_id_flush  = if_id_flush_raw  && !out_gate;
    id_ex_bubble = id_ex_bubble_raw && !out_gate;
    pc_vec_sel   = pc_vec_sel_raw   && !out_gate;
    int_ack      = int_ack_raw      && !out_gate;
    in_isr       = in_isr_q         && !out_gate;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a cycle model pushes expected outputs per
// driven cycle, which are popped and compared at the following falling edge.
module tb_pipe_hazard_ctrl;

  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_use_rs1, id_use_rs2, ex_mem_rd;
  logic       id_branch_take, id_returni, irq;
  logic [3:0] id_rs1, id_rs2, ex_reg_dst;
  logic       pc_hold, if_id_hold, if_id_flush, id_ex_bubble, pc_vec_sel, int_ack, in_isr;

  // stimulus staging, copied onto the DUT pins by applyStimulus
  logic       s_rst, s_v, s_u1, s_u2, s_mr, s_br, s_ret, s_irq;
  logic [3:0] s_rs1, s_rs2, s_dst;

  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pc_vec_sel;
    logic int_ack;
    logic in_isr;
  } exp_t;

  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ack_cnt = 0;

  // reference model state: 0 RUN, 1 DRAIN, 2 VECTOR
  int   m_state = 0;
  int   m_cnt = 0;
  logic m_pend = 1'b0;
  logic m_isr = 1'b0;
  logic m_rstdly = 1'b1;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_rd(ex_mem_rd),
    .ex_reg_dst(ex_reg_dst), .id_branch_take(id_branch_take), .id_returni(id_returni),
    .irq(irq), .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pc_vec_sel(pc_vec_sel), .int_ack(int_ack), .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (int_ack === 1'b1) ack_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic idle();
    s_rst = 1'b0; s_v = 1'b0; s_u1 = 1'b0; s_u2 = 1'b0; s_mr = 1'b0;
    s_br = 1'b0; s_ret = 1'b0; s_irq = 1'b0;
    s_rs1 = 4'd0; s_rs2 = 4'd0; s_dst = 4'd0;
  endtask

  task automatic applyStimulus();
    exp_t e, got;
    logic hz, gate;
    @(posedge clk);
    #1;
    rst = s_rst; id_valid = s_v; id_rs1 = s_rs1; id_rs2 = s_rs2;
    id_use_rs1 = s_u1; id_use_rs2 = s_u2; ex_mem_rd = s_mr; ex_reg_dst = s_dst;
    id_branch_take = s_br; id_returni = s_ret; irq = s_irq;

    hz = s_v && s_mr && ((s_u1 && (s_rs1 == s_dst)) || (s_u2 && (s_rs2 == s_dst)));
    gate = s_rst || m_rstdly;
    e = '0;
    if (!gate) begin
      e.in_isr = m_isr;
      if (m_state == 1) begin
        e.pc_hold = 1'b1; e.if_id_flush = 1'b1;
      end else if (m_state == 2) begin
        e.pc_vec_sel = 1'b1; e.int_ack = 1'b1; e.if_id_flush = 1'b1;
      end else if (hz) begin
        e.pc_hold = 1'b1; e.if_id_hold = 1'b1; e.id_ex_bubble = 1'b1;
      end else if (s_v && s_br) begin
        e.if_id_flush = 1'b1;
      end
    end
    exp_q.push_back(e);

    @(negedge clk);
    got = exp_q.pop_front();
    checkOutput("pc_hold", {31'd0, pc_hold}, {31'd0, got.pc_hold});
    checkOutput("if_id_hold", {31'd0, if_id_hold}, {31'd0, got.if_id_hold});
    checkOutput("if_id_flush", {31'd0, if_id_flush}, {31'd0, got.if_id_flush});
    checkOutput("id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, got.id_ex_bubble});
    checkOutput("pc_vec_sel", {31'd0, pc_vec_sel}, {31'd0, got.pc_vec_sel});
    checkOutput("int_ack", {31'd0, int_ack}, {31'd0, got.int_ack});
    checkOutput("in_isr", {31'd0, in_isr}, {31'd0, got.in_isr});
    checkOutput("hold_flush_excl", {31'd0, if_id_hold & if_id_flush}, 32'd0);
    checkOutput("vec_hold_excl", {31'd0, pc_vec_sel & pc_hold}, 32'd0);

    // advance the model to the state it will hold after the coming rising edge
    if (s_rst) begin
      m_state = 0; m_cnt = 0; m_pend = 1'b0; m_isr = 1'b0; m_rstdly = 1'b1;
    end else begin
      logic n_pend, n_isr;
      int n_state, n_cnt;
      m_rstdly = 1'b0;
      n_pend = m_pend; n_isr = m_isr; n_state = m_state; n_cnt = m_cnt;
      if (m_state == 0 && s_irq && !m_isr) n_pend = 1'b1;
      if (m_state == 0) begin
        if (hz) n_state = 0;
        else if (s_v && s_br) n_state = 0;
        else if (s_v && s_ret && m_isr) n_isr = 1'b0;
        else if (m_pend) begin
          n_state = 1; n_cnt = DC - 1;
        end
      end else if (m_state == 1) begin
        if (m_cnt == 0) n_state = 2;
        else n_cnt = m_cnt - 1;
      end else begin
        n_pend = 1'b0; n_isr = 1'b1; n_state = 0;
      end
      m_state = n_state; m_cnt = n_cnt; m_pend = n_pend; m_isr = n_isr;
    end
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      applyStimulus();
    end
  endtask

  initial begin
    idle();
    rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0; ex_mem_rd = 1'b0; ex_reg_dst = '0; id_branch_take = 1'b0;
    id_returni = 1'b0; irq = 1'b0;

    // reset, then a hazard in the first post-reset cycle must stay masked
    s_rst = 1'b1; applyStimulus(); applyStimulus();
    idle(); s_v = 1'b1; s_mr = 1'b1; s_dst = 4'd5; s_rs1 = 4'd5; s_u1 = 1'b1; applyStimulus();
    idleCycles(1);

    // load-use on rs1, then same operands without use, then rs2 on register 0
    idle(); s_v = 1'b1; s_mr = 1'b1; s_dst = 4'd5; s_rs1 = 4'd5; s_u1 = 1'b1; applyStimulus();
    s_u1 = 1'b0; applyStimulus();
    idle(); s_v = 1'b1; s_mr = 1'b1; s_dst = 4'd0; s_rs2 = 4'd0; s_u2 = 1'b1; applyStimulus();
    s_v = 1'b0; applyStimulus();
    idle(); s_v = 1'b1; s_mr = 1'b0; s_dst = 4'd7; s_rs1 = 4'd7; s_u1 = 1'b1; applyStimulus();

    // taken branch, and a branch with an invalid ID slot
    idle(); s_v = 1'b1; s_br = 1'b1; applyStimulus();
    s_v = 1'b0; applyStimulus();

    // interrupt entry
    idle(); s_irq = 1'b1; applyStimulus();
    idleCycles(7);

    // irq held high inside the ISR, then returni reopens entry
    for (int i = 0; i < 4; i++) begin
      idle(); s_irq = 1'b1; applyStimulus();
    end
    idle(); s_irq = 1'b1; s_v = 1'b1; s_ret = 1'b1; applyStimulus();
    idle(); s_irq = 1'b1; applyStimulus();
    idleCycles(7);

    // leave the ISR, then a hazard collides with the pending request
    idle(); s_v = 1'b1; s_ret = 1'b1; applyStimulus();
    idleCycles(1);
    idle(); s_irq = 1'b1; applyStimulus();
    idle(); s_v = 1'b1; s_mr = 1'b1; s_dst = 4'd9; s_rs2 = 4'd9; s_u2 = 1'b1; applyStimulus();
    idleCycles(7);

    // leave the ISR, then reset lands in the second drain cycle
    idle(); s_v = 1'b1; s_ret = 1'b1; applyStimulus();
    idleCycles(1);
    idle(); s_irq = 1'b1; applyStimulus();
    idleCycles(2);
    idle(); s_rst = 1'b1; applyStimulus();
    idleCycles(8);

    checkOutput("ack_total", ack_cnt, 32'd3);

    // random traffic with a narrow register range so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      s_rst = ($urandom_range(0, 79) == 0);
      s_v   = ($urandom_range(0, 3) != 0);
      s_u1  = $urandom_range(0, 1);
      s_u2  = $urandom_range(0, 1);
      s_mr  = ($urandom_range(0, 3) == 0);
      s_br  = ($urandom_range(0, 4) == 0);
      s_ret = ($urandom_range(0, 7) == 0);
      s_irq = ($urandom_range(0, 5) == 0);
      s_rs1 = 4'($urandom_range(0, 3));
      s_rs2 = 4'($urandom_range(0, 3));
      s_dst = 4'($urandom_range(0, 3));
      applyStimulus();
    end
    idleCycles(2);

    checkOutput("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
